divider_unit: RTL
=================

DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock.
REQ-002 SHALL provide: nrst  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide: en  input  1  global pipeline enable; when low, state and outputs hold.
REQ-004 SHALL provide: flush  input  1  synchronous abort of any in-flight operation.
REQ-005 SHALL provide: exe_div_valid  input  1  EXE-stage instruction is DIV/DIVU/REM/REMU.
REQ-006 SHALL provide: exe_div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL provide: exe_opA  input  32  dividend (forwarded rs1).
REQ-008 SHALL provide: exe_opB  input  32  divisor (forwarded rs2).
REQ-009 SHALL provide: div_stall  output  1  hold request to the IF/ID/EXE pipeline registers.
REQ-010 SHALL provide: div_done  output  1  one-cycle pulse when div_result is valid.
REQ-011 SHALL provide: div_result  output  32  quotient or remainder, per exe_div_op.
REQ-012 SHALL provide: div_busy  output  1  high while in CALC.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE: when en and exe_div_valid are high, SHALL latch opA, opB, and op.
REQ-015 On acceptance with a zero divisor or signed overflow, SHALL go to DONE next cycle (fast path).
REQ-016 On any other acceptance, SHALL load the magnitudes, clear the 6-bit counter, and go to CALC.
REQ-017 Magnitudes: DIV/REM SHALL use two's-complement absolute values; DIVU/REMU SHALL use raw operands.
REQ-018 CALC SHALL perform one restoring shift-subtract step per en-high cycle, MSB first, over a 64-bit remainder:quotient register.
REQ-019 CALC SHALL increment the counter each step and go to DONE after step 32 (count 31).
REQ-020 Sign fix at DONE: negate the quotient if operand signs differ (signed ops only); the remainder SHALL take the dividend's sign.
REQ-021 Divide by zero: quotient SHALL be 0xFFFFFFFF and remainder SHALL equal opA, for both signed and unsigned ops.
REQ-022 Overflow (DIV/REM, opA=0x80000000, opB=0xFFFFFFFF): quotient SHALL be 0x80000000 and remainder 0.
REQ-023 div_stall SHALL be combinational: high when exe_div_valid and state is not DONE, including the acceptance cycle; low in DONE.
REQ-024 Latency, normal path: accepted at cycle T, div_done and div_result valid at T+33, div_stall high for T..T+32.
REQ-025 Latency, fast path: done at T+1, div_stall high only at T.
REQ-026 DONE SHALL return to IDLE on the next en-high edge, which SHALL NOT re-accept the same instruction.
REQ-027 A new div that follows back-to-back SHALL be accepted in the IDLE cycle after DONE.
REQ-028 In DONE with en low, SHALL hold DONE, div_result, and div_done.
REQ-029 div_result SHALL hold its last value outside DONE; div_done SHALL be high only in DONE.
REQ-030 Operand or op changes during CALC SHALL be ignored; only latched values are used.
REQ-031 exe_div_valid dropping during CALC (no flush) SHALL NOT abort the operation.

Reset
REQ-032 When nrst is low at a clock edge: state IDLE, counter 0, internal registers 0, div_result 0, div_done 0, div_busy 0.
REQ-033 When nrst is low, div_stall SHALL be 0.
REQ-034 flush SHALL have identical effect to reset and override en, whether in IDLE, CALC, or DONE.
REQ-035 Reset and flush SHALL take priority over a simultaneous acceptance.

Verification
REQ-036 DIVU 100/7 at T -> div_done at T+33, div_result=14; REMU same operands -> 2; div_stall high for 33 cycles.
REQ-037 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-038 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both at T+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, both at T+1.
REQ-039 Flush asserted at T+10 of a CALC -> IDLE, div_stall 0, div_busy 0 next cycle, no div_done pulse.
REQ-040 en low for 5 cycles mid-CALC -> done delayed exactly 5 cycles with correct result; en low in DONE -> result held.
REQ-041 Back-to-back DIVU 100/7 then REMU 9/4 -> two div_done pulses 34 cycles apart with results 14 and 1; nrst low mid-CALC -> all outputs 0.

Source files
------------

// File: rtl/divider_unit.sv
// Iterative RV32M divider: DIV/DIVU/REM/REMU, 33 cycles normal path, 1 cycle for divide-by-zero/overflow.
// Stalls the front pipeline while a divide is pending; en low freezes everything, flush aborts like reset.
module divider_unit (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic        flush,
    input  logic        exe_div_valid,
    input  logic [1:0]  exe_div_op,
    input  logic [31:0] exe_opA,
    input  logic [31:0] exe_opB,
    output logic        div_stall,
    output logic        div_done,
    output logic [31:0] div_result,
    output logic        div_busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] magb_q;
    logic [63:0] rq_q;
    logic [5:0]  cnt_q;
    logic [31:0] result_q;
    logic        done_q;
    logic        busy_q;

    logic        in_signed;
    logic        in_zero;
    logic        in_ovf;
    logic [31:0] in_maga;
    logic [31:0] in_magb;
    logic [31:0] fast_res;

    logic [32:0] top;
    logic [32:0] diff;
    logic [31:0] new_rem;
    logic [63:0] step_rq;
    logic        signed_q;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] calc_res;

    assign in_signed = ~exe_div_op[0];
    assign in_zero   = (exe_opB == 32'h0);
    assign in_ovf    = in_signed && (exe_opA == 32'h8000_0000) && (exe_opB == 32'hFFFF_FFFF);
    assign in_maga   = (in_signed && exe_opA[31]) ? -exe_opA : exe_opA;
    assign in_magb   = (in_signed && exe_opB[31]) ? -exe_opB : exe_opB;
    assign fast_res  = in_zero ? (exe_div_op[1] ? exe_opA : 32'hFFFF_FFFF)
                               : (exe_div_op[1] ? 32'h0 : 32'h8000_0000);

    // Partial remainder is < divisor, so after the shift it needs 33 bits for the trial subtract.
    assign top      = rq_q[63:31];
    assign diff     = top - {1'b0, magb_q};
    assign new_rem  = diff[32] ? top[31:0] : diff[31:0];
    assign step_rq  = {new_rem, rq_q[30:0], ~diff[32]};

    assign signed_q = ~op_q[0];
    assign quo_fix  = (signed_q && (a_q[31] ^ b_q[31])) ? -step_rq[31:0] : step_rq[31:0];
    assign rem_fix  = (signed_q && a_q[31]) ? -step_rq[63:32] : step_rq[63:32];
    assign calc_res = op_q[1] ? rem_fix : quo_fix;

    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            magb_q   <= 32'h0;
            rq_q     <= 64'h0;
            cnt_q    <= 6'd0;
            result_q <= 32'h0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (exe_div_valid) begin
                        op_q <= exe_div_op;
                        a_q  <= exe_opA;
                        b_q  <= exe_opB;
                        if (in_zero || in_ovf) begin
                            result_q <= fast_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            rq_q    <= {32'h0, in_maga};
                            magb_q  <= in_magb;
                            cnt_q   <= 6'd0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rq_q  <= step_rq;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_q <= calc_res;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    // Leaving DONE never accepts: the EXE instruction only advances on this edge.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_stall  = nrst && !flush && exe_div_valid && (state_q != DONE);
    assign div_done   = done_q;
    assign div_result = result_q;
    assign div_busy   = busy_q;

endmodule
